gmii_capture_writer: RTL



---
 rtl/gmii_capture_writer_pkg.sv | 26 ++
 rtl/gmii_capture_writer_if.sv | 12 +
 rtl/gmii_word_packer.sv | 53 +++++
 rtl/gmii_capture_writer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/gmii_capture_writer_pkg.sv
// Shared types and width helpers for the GMII capture write path.
package gmii_capture_writer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SOF = 3'd1,
    CAPTURE  = 3'd2,
    FLUSH    = 3'd3,
    DONE     = 3'd4
  } cap_state_e;

  function automatic int unsigned bpw(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // A one-byte word still needs a one-bit lane index.
  function automatic int unsigned lane_width(input int unsigned data_width);
    return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
  endfunction

  function automatic int unsigned bcnt_width(input int unsigned addr_width,
                                             input int unsigned data_width);
    return addr_width + $clog2(data_width / 8) + 1;
  endfunction

endpackage

// File: rtl/gmii_capture_writer_if.sv
// Write port of the dual-port capture RAM; the writer is master, the RAM slave.
interface gmii_capture_writer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (output mem_wr, mem_addr, mem_data);
  modport slave  (input  mem_wr, mem_addr, mem_data);
endinterface

// File: rtl/gmii_word_packer.sv
// Little-endian byte-to-word packer; lanes are zeroed after every word so a
// flushed partial word carries zeros in its unwritten lanes.
module gmii_word_packer
  import gmii_capture_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                              i_clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              byte_en,
  input  logic [7:0]                        byte_in,
  input  logic                              flush,
  output logic [lane_width(DATA_WIDTH)-1:0] lane,
  output logic [DATA_WIDTH-1:0]             word_c,
  output logic                              word_done_c
);

  localparam int unsigned BPW = bpw(DATA_WIDTH);
  localparam int unsigned LW  = lane_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shift_q;

  // Current word with the incoming byte dropped into its lane.
  always_comb begin
    word_c      = shift_q;
    word_done_c = byte_en && (lane == LW'(BPW - 1));
    for (int unsigned k = 0; k < BPW; k++) begin
      if (byte_en && (lane == LW'(k))) begin
        word_c[8*k +: 8] = byte_in;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst || clear) begin
      lane    <= '0;
      shift_q <= '0;
    end else if (byte_en) begin
      if (word_done_c) begin
        lane    <= '0;
        shift_q <= '0;
      end else begin
        lane    <= lane + LW'(1);
        shift_q <= word_c;
      end
    end else if (flush) begin
      lane    <= '0;
      shift_q <= '0;
    end
  end

endmodule

// File: rtl/gmii_capture_writer.sv
// Armed GMII frame capture into the write port of the capture RAM, with
// byte count, truncation and receive-error status.
module gmii_capture_writer
  import gmii_capture_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BCNT_WIDTH = bcnt_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                   i_clk,
  input  logic                   rst,
  input  logic [7:0]             gmii_rxd,
  input  logic                   gmii_rx_dv,
  input  logic                   gmii_rx_er,
  input  logic                   arm,
  input  logic                   abort,
  gmii_capture_writer_if.master  mem_if,
  output logic                   busy,
  output logic                   done,
  output logic [BCNT_WIDTH-1:0]  byte_count,
  output logic                   truncated,
  output logic                   frame_err
);

  localparam int unsigned LW = lane_width(DATA_WIDTH);

  cap_state_e            state;
  logic                  dv_q;
  logic                  full_q;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [LW-1:0]         lane;
  logic [DATA_WIDTH-1:0] word_c;
  logic                  word_done_c;
  logic                  start_c;
  logic                  sof_c;
  logic                  accept_c;
  logic                  flush_c;
  logic                  write_c;
  logic                  in_busy_c;

  // Byte acceptance and write requests; abort suppresses both.
  always_comb begin
    in_busy_c = (state == WAIT_SOF) || (state == CAPTURE) || (state == FLUSH);
    start_c   = ((state == IDLE) || (state == DONE)) && arm && !abort;
    sof_c     = (state == WAIT_SOF) && gmii_rx_dv && !dv_q;
    accept_c  = !abort && (sof_c || ((state == CAPTURE) && gmii_rx_dv && !full_q));
    flush_c   = !abort && (state == CAPTURE) && !gmii_rx_dv && (lane != '0);
    write_c   = (accept_c && word_done_c) || flush_c;
  end

  gmii_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .i_clk       (i_clk),
    .rst         (rst),
    .clear       (start_c),
    .byte_en     (accept_c),
    .byte_in     (gmii_rxd),
    .flush       (flush_c),
    .lane        (lane),
    .word_c      (word_c),
    .word_done_c (word_done_c)
  );

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state           <= IDLE;
      dv_q            <= 1'b0;
      full_q          <= 1'b0;
      wr_addr         <= '0;
      mem_if.mem_wr   <= 1'b0;
      mem_if.mem_addr <= '0;
      mem_if.mem_data <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      byte_count      <= '0;
      truncated       <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      dv_q          <= gmii_rx_dv;
      mem_if.mem_wr <= write_c;

      // The address saturates at the last word; full_q blocks further bytes.
      if (write_c) begin
        mem_if.mem_addr <= wr_addr;
        mem_if.mem_data <= word_c;
        if (wr_addr == '1) begin
          full_q <= 1'b1;
        end else begin
          wr_addr <= wr_addr + ADDR_WIDTH'(1);
        end
      end

      if (accept_c) begin
        byte_count <= byte_count + BCNT_WIDTH'(1);
      end

      if (start_c) begin
        state      <= WAIT_SOF;
        busy       <= 1'b1;
        done       <= 1'b0;
        byte_count <= '0;
        truncated  <= 1'b0;
        frame_err  <= 1'b0;
        wr_addr    <= '0;
        full_q     <= 1'b0;
      end else if (abort && in_busy_c) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          WAIT_SOF: begin
            if (sof_c) begin
              state <= CAPTURE;
              if (gmii_rx_er) frame_err <= 1'b1;
            end
          end
          CAPTURE: begin
            if (gmii_rx_dv) begin
              if (gmii_rx_er) frame_err <= 1'b1;
              if (full_q)     truncated <= 1'b1;
            end else if (lane != '0) begin
              state <= FLUSH;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          FLUSH: begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
